// File: rtl/lsu_pkg.sv
// lsu_pkg
// Shared definitions for the load/store unit Wishbone master.
// Contents:
//   LSU_XLEN          data/address width the helper functions operate on
//   F3_B/H/W/BU/HU    RV32I funct3 size codes (also used as the bus size code)
//   lsu_state_t       state encoding of the transaction sequencer
//   lsu_req_bad()     flags misaligned or illegal requests before any bus activity
//   lsu_extend()      sign/zero extension of right-aligned load data
//   lsu_store_data()  right-aligned store data with the unused upper bytes cleared
package lsu_pkg;

    localparam int LSU_XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP,
        ST_ERR
    } lsu_state_t;

    // A request is rejected when its size code is not a legal RV32I
    // load/store code, or when the address is not naturally aligned for
    // the access size. Stores only have the three signed-looking codes.
    function automatic logic lsu_req_bad(
        input logic       we,
        input logic [2:0] funct3,
        input logic [1:0] addr_lo
    );
        logic bad;
        bad = 1'b0;
        case (funct3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = addr_lo[0];
            F3_W:    bad = (addr_lo != 2'b00);
            F3_BU:   bad = we;
            F3_HU:   bad = we | addr_lo[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Load data arrives right-aligned; widen it according to the size code.
    function automatic logic [LSU_XLEN-1:0] lsu_extend(
        input logic [2:0]          funct3,
        input logic [LSU_XLEN-1:0] data
    );
        logic [LSU_XLEN-1:0] result;
        result = data;
        case (funct3)
            F3_B:    result = {{(LSU_XLEN-8){data[7]}}, data[7:0]};
            F3_H:    result = {{(LSU_XLEN-16){data[15]}}, data[15:0]};
            F3_W:    result = data;
            F3_BU:   result = {{(LSU_XLEN-8){1'b0}}, data[7:0]};
            F3_HU:   result = {{(LSU_XLEN-16){1'b0}}, data[15:0]};
            default: result = '0;
        endcase
        return result;
    endfunction

    // Store data stays right-aligned on the bus; bytes beyond the access
    // size are forced to zero so the responder never sees stale upper bits.
    function automatic logic [LSU_XLEN-1:0] lsu_store_data(
        input logic [2:0]          funct3,
        input logic [LSU_XLEN-1:0] data
    );
        logic [LSU_XLEN-1:0] result;
        result = data;
        case (funct3)
            F3_B:    result = {{(LSU_XLEN-8){1'b0}}, data[7:0]};
            F3_H:    result = {{(LSU_XLEN-16){1'b0}}, data[15:0]};
            default: result = data;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/wb_lsu_master.sv
// wb_lsu_master
// Load/store initiator sitting between the core memory stage and the
// pipelined Wishbone data bus. One request is accepted per handshake,
// checked for alignment/legality, turned into a single bus transaction,
// and answered with a one-cycle response carrying extended load data or
// an error flag. Only one transaction is ever outstanding.
//
// Ports:
//   i_clk, i_reset                  clock, synchronous active-high reset
//   i_req_valid / o_req_ready       request handshake (ready only when idle)
//   i_req_we, i_req_funct3          store flag and RV32I size code
//   i_req_addr, i_req_wdata         byte address and right-aligned store data
//   o_rsp_valid, o_rsp_rdata,
//   o_rsp_err                       one-cycle completion with data or error
//   o_wb_cyc, o_wb_stb, o_wb_we     Wishbone control
//   o_wb_addr, o_wb_data, o_wb_sel  byte address, masked store data, size code
//   i_wb_data, i_wb_stall, i_wb_ack responder read data, stall and ack
//
// All outputs are registered inside the single sequencer block below.
module wb_lsu_master
    import lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 64
) (
    input  logic            i_clk,
    input  logic            i_reset,

    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic            i_req_we,
    input  logic [2:0]      i_req_funct3,
    input  logic [XLEN-1:0] i_req_addr,
    input  logic [XLEN-1:0] i_req_wdata,

    output logic            o_rsp_valid,
    output logic [XLEN-1:0] o_rsp_rdata,
    output logic            o_rsp_err,

    output logic            o_wb_cyc,
    output logic            o_wb_stb,
    output logic            o_wb_we,
    output logic [XLEN-1:0] o_wb_addr,
    output logic [XLEN-1:0] o_wb_data,
    output logic [2:0]      o_wb_sel,
    input  logic [XLEN-1:0] i_wb_data,
    input  logic            i_wb_stall,
    input  logic            i_wb_ack
);

    localparam int             CW     = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TO_MAX = CW'(TIMEOUT);

    lsu_state_t    state;
    logic [CW-1:0] wait_count;

    // Sequencer: owns the state, the timeout counter and every output.
    // The request fields are latched straight into the bus output
    // registers on accept, so o_wb_sel/o_wb_we double as the remembered
    // size code and direction when the ack arrives. An ack in REQ or WAIT
    // always wins over a timeout in the same cycle; the counter is only
    // consulted when no ack is present.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            wait_count  <= '0;
            o_req_ready <= 1'b1;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= '0;
            o_rsp_err   <= 1'b0;
            o_wb_cyc    <= 1'b0;
            o_wb_stb    <= 1'b0;
            o_wb_we     <= 1'b0;
            o_wb_addr   <= '0;
            o_wb_data   <= '0;
            o_wb_sel    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        o_req_ready <= 1'b0;
                        wait_count  <= '0;
                        if (lsu_req_bad(i_req_we, i_req_funct3, i_req_addr[1:0])) begin
                            state       <= ST_ERR;
                            o_rsp_valid <= 1'b1;
                            o_rsp_err   <= 1'b1;
                            o_rsp_rdata <= '0;
                        end else begin
                            state     <= ST_REQ;
                            o_wb_cyc  <= 1'b1;
                            o_wb_stb  <= 1'b1;
                            o_wb_we   <= i_req_we;
                            o_wb_addr <= i_req_addr;
                            o_wb_data <= lsu_store_data(i_req_funct3, i_req_wdata);
                            o_wb_sel  <= i_req_funct3;
                        end
                    end
                end

                ST_REQ, ST_WAIT: begin
                    if (i_wb_ack) begin
                        state       <= ST_RESP;
                        o_wb_cyc    <= 1'b0;
                        o_wb_stb    <= 1'b0;
                        o_rsp_valid <= 1'b1;
                        o_rsp_err   <= 1'b0;
                        o_rsp_rdata <= o_wb_we ? '0 : lsu_extend(o_wb_sel, i_wb_data);
                    end else if (wait_count == TO_MAX) begin
                        state       <= ST_ERR;
                        o_wb_cyc    <= 1'b0;
                        o_wb_stb    <= 1'b0;
                        o_rsp_valid <= 1'b1;
                        o_rsp_err   <= 1'b1;
                        o_rsp_rdata <= '0;
                    end else begin
                        wait_count <= wait_count + CW'(1);
                        if (state == ST_REQ && !i_wb_stall) begin
                            state    <= ST_WAIT;
                            o_wb_stb <= 1'b0;
                        end
                    end
                end

                ST_RESP, ST_ERR: begin
                    state       <= ST_IDLE;
                    o_req_ready <= 1'b1;
                    o_rsp_valid <= 1'b0;
                    o_rsp_err   <= 1'b0;
                    o_rsp_rdata <= '0;
                end

                default: begin
                    state       <= ST_IDLE;
                    o_req_ready <= 1'b1;
                    o_rsp_valid <= 1'b0;
                    o_rsp_err   <= 1'b0;
                    o_wb_cyc    <= 1'b0;
                    o_wb_stb    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_lsu_master.sv
// tb_wb_lsu_master
// Self-checking bench for wb_lsu_master. The bench plays the core and a
// Wishbone responder with a configurable stall count and ack delay, and
// compares every transaction against expectations derived from the
// load/store rules (alignment, extension, timing) using plain arithmetic.
module tb_wb_lsu_master;

    localparam int TIMEOUT = 8;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_we = 1'b0;
    logic [2:0]  i_req_funct3 = 3'b000;
    logic [31:0] i_req_addr = '0;
    logic [31:0] i_req_wdata = '0;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [31:0] o_wb_addr;
    logic [31:0] o_wb_data;
    logic [2:0]  o_wb_sel;
    logic [31:0] i_wb_data = '0;
    logic        i_wb_stall = 1'b0;
    logic        i_wb_ack = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    wb_lsu_master #(.XLEN(32), .TIMEOUT(TIMEOUT)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_we     (i_req_we),
        .i_req_funct3 (i_req_funct3),
        .i_req_addr   (i_req_addr),
        .i_req_wdata  (i_req_wdata),
        .o_rsp_valid  (o_rsp_valid),
        .o_rsp_rdata  (o_rsp_rdata),
        .o_rsp_err    (o_rsp_err),
        .o_wb_cyc     (o_wb_cyc),
        .o_wb_stb     (o_wb_stb),
        .o_wb_we      (o_wb_we),
        .o_wb_addr    (o_wb_addr),
        .o_wb_data    (o_wb_data),
        .o_wb_sel     (o_wb_sel),
        .i_wb_data    (i_wb_data),
        .i_wb_stall   (i_wb_stall),
        .i_wb_ack     (i_wb_ack)
    );

    // Free-running clock, 10 time units per period.
    always #5 i_clk = ~i_clk;

    // Advance one clock and land just after the rising edge, where outputs
    // are sampled and new inputs are driven.
    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Reference rules: which requests never reach the bus.
    function automatic logic modelIllegal(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        case (f3)
            3'd0:    return 1'b0;
            3'd1:    return (addr % 2) != 0;
            3'd2:    return (addr % 4) != 0;
            3'd4:    return we;
            3'd5:    return we || ((addr % 2) != 0);
            default: return 1'b1;
        endcase
    endfunction

    // Reference load extension computed numerically from the low byte/half.
    function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] b;
        logic [31:0] h;
        b = d % 256;
        h = d % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? b - 32'd256 : b;
            3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] modelStore(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'd0:    return d % 256;
            3'd1:    return d % 65536;
            default: return d;
        endcase
    endfunction

    // One complete transaction: issue the request, act as the responder
    // (stall for stallCycles stb cycles, ack ackDelay cycles after the stb
    // is taken), then check timing, bus fields and response contents.
    task automatic applyStimulus(input string name, input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input int stallCycles, input int ackDelay,
                                 input logic [31:0] busData, input bit ackEnable);
        logic        bad;
        int          expRsp;
        logic        expErr;
        logic [31:0] expData;
        int          c;
        int          rspAt;
        int          stbCount;
        int          stbAfter;
        int          acceptAt;
        bit          busAccepted;
        bit          acked;
        bit          sawCyc;
        logic        rspErr;
        logic        rspCyc;
        logic [31:0] rspData;
        logic [31:0] seenAddr;
        logic [31:0] seenData;
        logic [2:0]  seenSel;
        logic        seenWe;

        bad = modelIllegal(we, f3, addr);
        if (bad) begin
            expRsp = 1; expErr = 1'b1; expData = '0;
        end else if (ackEnable && (stallCycles + ackDelay <= TIMEOUT)) begin
            expRsp = stallCycles + ackDelay + 2; expErr = 1'b0;
            expData = we ? 32'd0 : modelLoad(f3, busData);
        end else begin
            expRsp = TIMEOUT + 2; expErr = 1'b1; expData = '0;
        end

        rspAt = -1; stbCount = 0; stbAfter = 0; acceptAt = 0;
        busAccepted = 0; acked = 0; sawCyc = 0;
        rspErr = 1'bx; rspCyc = 1'bx; rspData = 'x;
        seenAddr = 'x; seenData = 'x; seenSel = 'x; seenWe = 1'bx;

        checkOutput({name, ":ready"}, {31'd0, o_req_ready}, 32'd1);

        i_req_valid  = 1'b1;
        i_req_we     = we;
        i_req_funct3 = f3;
        i_req_addr   = addr;
        i_req_wdata  = wdata;
        tick();
        i_req_valid  = 1'b0;
        c = 1;

        while (c <= TIMEOUT + 6) begin
            if (o_rsp_valid) begin
                rspAt = c; rspErr = o_rsp_err; rspData = o_rsp_rdata; rspCyc = o_wb_cyc;
                break;
            end
            if (o_wb_cyc) sawCyc = 1;
            i_wb_ack   = 1'b0;
            i_wb_stall = 1'b0;
            i_wb_data  = busData;
            if (o_wb_stb && busAccepted) stbAfter++;
            if (o_wb_stb && !busAccepted) begin
                stbCount++;
                if (stbCount == 1) begin
                    seenAddr = o_wb_addr; seenData = o_wb_data; seenSel = o_wb_sel; seenWe = o_wb_we;
                end
                if (stbCount > stallCycles) begin
                    busAccepted = 1; acceptAt = c;
                end else begin
                    i_wb_stall = 1'b1;
                end
            end
            if (busAccepted && !acked && ackEnable && (c - acceptAt == ackDelay)) begin
                i_wb_ack = 1'b1; acked = 1;
            end
            tick();
            c++;
        end
        i_wb_ack   = 1'b0;
        i_wb_stall = 1'b0;

        checkOutput({name, ":rspCycle"}, rspAt, expRsp);
        checkOutput({name, ":rspErr"}, {31'd0, rspErr}, {31'd0, expErr});
        checkOutput({name, ":rspData"}, rspData, expData);
        checkOutput({name, ":cycAtRsp"}, {31'd0, rspCyc}, 32'd0);
        if (bad) begin
            checkOutput({name, ":noBus"}, {31'd0, sawCyc}, 32'd0);
        end else begin
            checkOutput({name, ":stbCycles"}, stbCount, stallCycles + 1);
            checkOutput({name, ":stbInWait"}, stbAfter, 0);
            checkOutput({name, ":wbAddr"}, seenAddr, addr);
            checkOutput({name, ":wbData"}, seenData, modelStore(f3, wdata));
            checkOutput({name, ":wbSel"}, {29'd0, seenSel}, {29'd0, f3});
            checkOutput({name, ":wbWe"}, {31'd0, seenWe}, {31'd0, we});
        end
        tick();
    endtask

    initial begin
        logic        rWe;
        logic [2:0]  rF3;
        logic [31:0] rAddr;

        // Reset state
        tick();
        tick();
        checkOutput("reset:ready", {31'd0, o_req_ready}, 32'd1);
        checkOutput("reset:rspValid", {31'd0, o_rsp_valid}, 32'd0);
        checkOutput("reset:rspErr", {31'd0, o_rsp_err}, 32'd0);
        checkOutput("reset:rdata", o_rsp_rdata, 32'd0);
        checkOutput("reset:cyc", {31'd0, o_wb_cyc}, 32'd0);
        checkOutput("reset:stb", {31'd0, o_wb_stb}, 32'd0);
        checkOutput("reset:wbAddr", o_wb_addr, 32'd0);
        i_reset = 1'b0;
        tick();

        // Directed cases
        applyStimulus("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 0, 1, 32'hDEADBEEF, 1);
        applyStimulus("lb13", 1'b0, 3'b000, 32'h13, 32'h0, 0, 1, 32'h00000080, 1);
        applyStimulus("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 0, 1, 32'h00000080, 1);
        applyStimulus("lh12", 1'b0, 3'b001, 32'h12, 32'h0, 0, 1, 32'h00008001, 1);
        applyStimulus("lhu12", 1'b0, 3'b101, 32'h12, 32'h0, 1, 2, 32'hFFFF8001, 1);
        applyStimulus("sh02", 1'b1, 3'b001, 32'h02, 32'h12345678, 3, 1, 32'hCAFEF00D, 1);
        applyStimulus("sbAck0", 1'b1, 3'b000, 32'h07, 32'hA5A5A5C3, 0, 0, 32'h0, 1);
        applyStimulus("lw06", 1'b0, 3'b010, 32'h06, 32'h0, 0, 1, 32'h11111111, 1);
        applyStimulus("lh11", 1'b0, 3'b001, 32'h11, 32'h0, 0, 1, 32'h11111111, 1);
        applyStimulus("f3011", 1'b0, 3'b011, 32'h20, 32'h0, 0, 1, 32'h11111111, 1);
        applyStimulus("sbu", 1'b1, 3'b100, 32'h20, 32'h0, 0, 1, 32'h11111111, 1);

        // Timeout boundary: ack on the last allowed cycle wins, one later loses
        applyStimulus("ackAtLimit", 1'b0, 3'b010, 32'h30, 32'h0, 0, TIMEOUT, 32'h0BADF00D, 1);
        applyStimulus("ackStallLimit", 1'b0, 3'b010, 32'h34, 32'h0, 3, TIMEOUT - 3, 32'h76543210, 1);
        applyStimulus("ackPastLimit", 1'b0, 3'b010, 32'h38, 32'h0, 0, TIMEOUT + 1, 32'h0, 1);
        applyStimulus("noAck", 1'b0, 3'b010, 32'h40, 32'h0, 0, 0, 32'h0, 0);

        // Stray ack while idle must not produce a response
        i_wb_ack = 1'b1;
        tick();
        i_wb_ack = 1'b0;
        checkOutput("stray:rspValid", {31'd0, o_rsp_valid}, 32'd0);
        checkOutput("stray:cyc", {31'd0, o_wb_cyc}, 32'd0);
        tick();
        checkOutput("stray:rspValid2", {31'd0, o_rsp_valid}, 32'd0);

        // Reset while waiting for ack
        i_req_valid = 1'b1; i_req_we = 1'b0; i_req_funct3 = 3'b010; i_req_addr = 32'h50;
        tick();
        i_req_valid = 1'b0;
        tick();
        checkOutput("midRst:waitCyc", {31'd0, o_wb_cyc}, 32'd1);
        checkOutput("midRst:waitStb", {31'd0, o_wb_stb}, 32'd0);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        checkOutput("midRst:cyc", {31'd0, o_wb_cyc}, 32'd0);
        checkOutput("midRst:ready", {31'd0, o_req_ready}, 32'd1);
        checkOutput("midRst:rspValid", {31'd0, o_rsp_valid}, 32'd0);
        i_wb_ack = 1'b1;
        i_wb_data = 32'h12345678;
        tick();
        i_wb_ack = 1'b0;
        checkOutput("midRst:lateAck", {31'd0, o_rsp_valid}, 32'd0);
        tick();
        checkOutput("midRst:lateAck2", {31'd0, o_rsp_valid}, 32'd0);
        applyStimulus("afterRst", 1'b0, 3'b010, 32'h54, 32'h0, 1, 1, 32'h89ABCDEF, 1);

        // Randomized traffic, back-to-back
        for (int i = 0; i < 40; i++) begin
            rWe   = 1'($urandom_range(0, 1));
            rF3   = 3'($urandom_range(0, 7));
            rAddr = $urandom & 32'h0000_FFFF;
            applyStimulus($sformatf("rnd%0d", i), rWe, rF3, rAddr, $urandom,
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
